// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO read and write controllers.
// Contents: FIFO_ASIZE/PTR_W sizing, ptr_t pointer type, bin2gray and gray2bin.
package async_fifo_pkg;

  localparam int unsigned FIFO_ASIZE = 4;
  localparam int unsigned PTR_W      = FIFO_ASIZE + 1;

  typedef logic [FIFO_ASIZE:0] ptr_t;

  // Binary to reflected Gray code.
  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    b[FIFO_ASIZE] = g[FIFO_ASIZE];
    for (int i = int'(FIFO_ASIZE) - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_empty_lvl_gray2bin_conv.sv
// gray2bin_conv: parametrised combinational Gray-to-binary converter.
// Ports: gray (in, W bits), bin (out, W bits, combinational).
module gray2bin_conv
  import async_fifo_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // XOR prefix from the MSB down.
  always_comb begin
    bin = '0;
    bin[W-1] = gray[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read-domain pointer/flag controller for the async FIFO.
// Keeps binary read address and Gray read pointer, registered empty,
// fill level and almost-empty flags, and an optional sticky underflow flag.
// Optional feature macro: RPTR_UDF_EN (enables rudf / rudf_clr behaviour).
// Ports:
//   rclk, rrst_n   read clock, async active-low reset
//   rinc           read request
//   raempty_thr    almost-empty threshold (quasi-static)
//   rq2_wptr       write pointer (Gray) synchronised into rclk
//   rudf_clr       clear sticky underflow
//   rpop           read accepted this cycle (combinational)
//   raddr          binary memory read address
//   rptr           Gray read pointer to the write domain
//   rempty         FIFO empty
//   raempty        level <= raempty_thr
//   rlevel         words available, 0..2**ASIZE
//   rudf           sticky underflow
module rptr_empty_lvl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ASIZE      = 4,
  parameter int unsigned AEMPTY_RST = 1
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rinc,
  input  logic [ASIZE:0]   raempty_thr,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic             rudf_clr,
  output logic             rpop,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   rlevel,
  output logic             rudf
);

  localparam int unsigned PW = ASIZE + 1;

  logic [ASIZE:0] rbin_q,    rbin_d;
  logic [ASIZE:0] rptr_q,    rptr_d;
  logic           rempty_q,  rempty_d;
  logic           raempty_q, raempty_d;
  logic [ASIZE:0] rlevel_q,  rlevel_d;
  logic           rudf_q,    rudf_d;
  logic [ASIZE:0] wbin;

  // AEMPTY_RST only documents the threshold assumed around reset.
  logic [31:0] unused_aempty_rst;
  assign unused_aempty_rst = 32'(AEMPTY_RST);

  gray2bin_conv #(.W(PW)) u_wptr_conv (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  // Next pointer, flags and level; everything derives from the post-pop pointer.
  always_comb begin
    rpop      = rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(rpop);
    rptr_d    = (rbin_d >> 1) ^ rbin_d;
    rempty_d  = (rptr_d == rq2_wptr);
    rlevel_d  = wbin - rbin_d;
    raempty_d = (rlevel_d <= raempty_thr);
  end

`ifdef RPTR_UDF_EN
  // Sticky underflow; a new underflow beats a simultaneous clear.
  always_comb begin
    rudf_d = rudf_q;
    if (rinc && rempty_q) begin
      rudf_d = 1'b1;
    end else if (rudf_clr) begin
      rudf_d = 1'b0;
    end
  end
`else
  logic unused_rudf_clr;
  assign unused_rudf_clr = rudf_clr;

  always_comb begin
    rudf_d = 1'b0;
  end
`endif

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      rlevel_q  <= '0;
      rudf_q    <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      rlevel_q  <= rlevel_d;
      rudf_q    <= rudf_d;
    end
  end

  assign raddr   = rbin_q[ASIZE-1:0];
  assign rptr    = rptr_q;
  assign rempty  = rempty_q;
  assign raempty = raempty_q;
  assign rlevel  = rlevel_q;
  assign rudf    = rudf_q;

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Directed bench for rptr_empty_lvl with ASIZE=4, raempty_thr=2.
module tb_rptr_empty_lvl;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] raempty_thr;
  logic [4:0] rq2_wptr;
  logic       rudf_clr;
  logic       rpop;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;
  logic       rudf;

  int vectors;
  int miscompares;

  rptr_empty_lvl #(.ASIZE(4), .AEMPTY_RST(2)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .rinc        (rinc),
    .raempty_thr (raempty_thr),
    .rq2_wptr    (rq2_wptr),
    .rudf_clr    (rudf_clr),
    .rpop        (rpop),
    .raddr       (raddr),
    .rptr        (rptr),
    .rempty      (rempty),
    .raempty     (raempty),
    .rlevel      (rlevel),
    .rudf        (rudf)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  logic [4:0] wb, rb, lvl, prev_rptr;
  logic       r, w, pop;

  initial begin
    vectors = 0;
    miscompares = 0;
    rrst_n = 1'b1;
    rinc = 1'b0;
    raempty_thr = 5'd2;
    rq2_wptr = 5'd0;
    rudf_clr = 1'b0;

    // Reset asserted between clock edges must take effect immediately.
    #2 rrst_n = 1'b0;
    #1;
    check("rst_rptr", 32'(rptr), 0);
    check("rst_raddr", 32'(raddr), 0);
    check("rst_rempty", 32'(rempty), 1);
    check("rst_raempty", 32'(raempty), 1);
    check("rst_rlevel", 32'(rlevel), 0);
    check("rst_rudf", 32'(rudf), 0);
    step();
    step();
    rrst_n = 1'b1;
    step();
    check("idle_rempty", 32'(rempty), 1);

    // Fill to level 5.
    for (int n = 1; n <= 5; n++) begin
      rq2_wptr = gray(5'(n));
      step();
      check("fill_rlevel", 32'(rlevel), 32'(n));
      check("fill_rempty", 32'(rempty), 0);
      check("fill_raempty", 32'(raempty), (n <= 2) ? 1 : 0);
    end

    // Drain five words with six requests.
    rinc = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      #1;
      check("drain_rpop", 32'(rpop), (k < 5) ? 1 : 0);
      check("drain_raddr", 32'(raddr), (k < 5) ? 32'(k) : 5);
      step();
      check("drain_rempty", 32'(rempty), (k >= 4) ? 1 : 0);
      check("drain_rlevel", 32'(rlevel), (k < 5) ? 32'(4 - k) : 0);
    end
    check("drain_rptr", 32'(rptr), 32'(gray(5'd5)));

    // Reads while empty.
`ifdef RPTR_UDF_EN
    rinc = 1'b1;
    step();
    check("udf_set", 32'(rudf), 1);
    check("udf_raddr_hold", 32'(raddr), 5);
    check("udf_rptr_hold", 32'(rptr), 32'(gray(5'd5)));
    rudf_clr = 1'b1;
    step();
    check("udf_set_wins", 32'(rudf), 1);
    rinc = 1'b0;
    step();
    check("udf_clear", 32'(rudf), 0);
    rudf_clr = 1'b0;
`else
    rinc = 1'b1;
    rudf_clr = 1'b1;
    step();
    check("udf_off", 32'(rudf), 0);
    check("udf_raddr_hold", 32'(raddr), 5);
    check("udf_rptr_hold", 32'(rptr), 32'(gray(5'd5)));
    rinc = 1'b0;
    rudf_clr = 1'b0;
`endif

    // Level 3, then threshold boundaries, then simultaneous pop + write.
    rq2_wptr = gray(5'd8);
    step();
    check("sim_pre_rlevel", 32'(rlevel), 3);
    check("sim_pre_raempty", 32'(raempty), 0);
    raempty_thr = 5'd3;
    step();
    check("thr_eq_raempty", 32'(raempty), 1);
    raempty_thr = 5'd16;
    step();
    check("thr16_raempty", 32'(raempty), 1);
    raempty_thr = 5'd0;
    step();
    check("thr0_raempty", 32'(raempty), 0);
    raempty_thr = 5'd2;
    step();
    rinc = 1'b1;
    rq2_wptr = gray(5'd9);
    step();
    check("sim_rlevel", 32'(rlevel), 3);
    check("sim_raempty", 32'(raempty), 0);
    check("sim_raddr", 32'(raddr), 6);
    rinc = 1'b0;

    // Full: binary pointers differ only in the MSB.
    rb = 5'd6;
    wb = 5'd22;
    rq2_wptr = gray(wb);
    step();
    check("full_rlevel", 32'(rlevel), 16);
    check("full_rempty", 32'(rempty), 0);
    check("full_raempty", 32'(raempty), 0);

    // Random traffic across pointer wrap against a reference model.
    lvl = wb - rb;
    prev_rptr = rptr;
    for (int it = 0; it < 40; it++) begin
      r = ($urandom_range(0, 3) != 0);
      w = (lvl < 5'd16) && ($urandom_range(0, 3) != 0);
      pop = r && (lvl != 5'd0);
      rinc = r;
      wb = wb + 5'(w);
      rq2_wptr = gray(wb);
      #1;
      check("wrap_rpop", 32'(rpop), 32'(pop));
      @(posedge rclk);
      #1;
      rb = rb + 5'(pop);
      lvl = wb - rb;
      check("wrap_rlevel", 32'(rlevel), 32'(lvl));
      check("wrap_rempty", 32'(rempty), (lvl == 5'd0) ? 1 : 0);
      check("wrap_consist", 32'(rempty), (rlevel == 5'd0) ? 1 : 0);
      check("wrap_le16", (rlevel <= 5'd16) ? 1 : 0, 1);
      check("wrap_rptr", 32'(rptr), 32'(gray(rb)));
      check("wrap_gray_step", ($countones(rptr ^ prev_rptr) <= 1) ? 1 : 0, 1);
      prev_rptr = rptr;
    end
    check("wrap_wrapped", (rb < 5'd6 || wb < 5'd22) ? 1 : 0, 1);

    // Mid-traffic asynchronous reset.
    rinc = 1'b1;
    rq2_wptr = gray(wb + 5'd1);
    @(posedge rclk);
    #3 rrst_n = 1'b0;
    #1;
    check("mid_rst_rptr", 32'(rptr), 0);
    check("mid_rst_raddr", 32'(raddr), 0);
    check("mid_rst_rempty", 32'(rempty), 1);
    check("mid_rst_raempty", 32'(raempty), 1);
    check("mid_rst_rlevel", 32'(rlevel), 0);
    check("mid_rst_rudf", 32'(rudf), 0);
    check("mid_rst_rpop", 32'(rpop), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
